// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The master side is the control FSM and the slave side is the datapath/IR.
interface mc_control_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic [1:0] FlagW;
   logic       PCS;
   logic       LinkSel;
   logic       InstrDone;
   logic       IllegalOp;

   modport master (
      input  Op, Funct, Rd,
      output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc,
             RegSrc, NextPC, RegW, MemW, FlagW, PCS, LinkSel, InstrDone, IllegalOp
   );

   modport slave (
      output Op, Funct, Rd,
      input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc,
             RegSrc, NextPC, RegW, MemW, FlagW, PCS, LinkSel, InstrDone, IllegalOp
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle ARM-subset processor.
// Optional macro MC_BL_EN adds the LINK state for branch-with-link.
module mc_control_fsm (
   input  logic           clk,
   input  logic           reset,
   mc_control_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
`ifdef MC_BL_EN
      , S_LINK   = 4'd11
`endif
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_irwrite, w_adrsrc, w_alusrca, w_nextpc, w_regw, w_memw;
   logic       w_alu_op, w_branch, w_linksel, w_done, w_unknown;
   logic [1:0] w_alusrcb, w_resultsrc;
   logic [1:0] w_cmd_ctrl, w_flagw;
   logic       w_cmd_ok, w_cmd_cmp, w_cmd_arith, w_nowrite;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // ALU command decode from Funct[4:1]; unsupported commands never write back.
   always_comb begin
      w_cmd_ctrl  = 2'b00;
      w_cmd_ok    = 1'b1;
      w_cmd_cmp   = 1'b0;
      w_cmd_arith = 1'b0;
      case (bus.Funct[4:1])
         4'b0100: begin w_cmd_ctrl = 2'b00; w_cmd_arith = 1'b1; end
         4'b0010: begin w_cmd_ctrl = 2'b01; w_cmd_arith = 1'b1; end
         4'b0000: begin w_cmd_ctrl = 2'b10; end
         4'b1100: begin w_cmd_ctrl = 2'b11; end
         4'b1010: begin w_cmd_ctrl = 2'b01; w_cmd_arith = 1'b1; w_cmd_cmp = 1'b1; end
         default: begin w_cmd_ctrl = 2'b00; w_cmd_ok = 1'b0; end
      endcase
   end

   assign w_nowrite = w_cmd_cmp | ~w_cmd_ok;

   always_comb begin
      w_flagw = 2'b00;
      if (w_alu_op && w_cmd_ok) begin
         w_flagw = w_cmd_cmp ? 2'b11 : {bus.Funct[0], bus.Funct[0] & w_cmd_arith};
      end else begin
         w_flagw = 2'b00;
      end
   end

   always_comb begin
      w_next      = S_FETCH;
      w_irwrite   = 1'b0;
      w_adrsrc    = 1'b0;
      w_alusrca   = 1'b0;
      w_alusrcb   = 2'b00;
      w_resultsrc = 2'b00;
      w_nextpc    = 1'b0;
      w_regw      = 1'b0;
      w_memw      = 1'b0;
      w_alu_op    = 1'b0;
      w_branch    = 1'b0;
      w_linksel   = 1'b0;
      w_done      = 1'b0;
      w_unknown   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_next = S_DECODE; w_irwrite = 1'b1; w_alusrca = 1'b1;
            w_alusrcb = 2'b10; w_resultsrc = 2'b10; w_nextpc = 1'b1;
         end
         S_DECODE: begin
            w_alusrca = 1'b1; w_alusrcb = 2'b10; w_resultsrc = 2'b10;
            case (bus.Op)
               2'b00:   w_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   w_next = S_MEMADR;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_UNKNOWN;
            endcase
         end
         S_MEMADR: begin
            w_alusrcb = 2'b01;
            w_next    = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin w_adrsrc = 1'b1; w_next = S_MEMWB; end
         S_MEMWB: begin w_resultsrc = 2'b01; w_regw = 1'b1; w_done = 1'b1; end
         S_MEMWR: begin w_adrsrc = 1'b1; w_memw = 1'b1; w_done = 1'b1; end
         S_EXECUTER: begin w_alu_op = 1'b1; w_next = S_ALUWB; end
         S_EXECUTEI: begin w_alusrcb = 2'b01; w_alu_op = 1'b1; w_next = S_ALUWB; end
         S_ALUWB: begin w_resultsrc = 2'b00; w_regw = ~w_nowrite; w_done = 1'b1; end
         S_BRANCH: begin
            w_alusrcb = 2'b01; w_resultsrc = 2'b10; w_branch = 1'b1;
`ifdef MC_BL_EN
            if (bus.Funct[4]) begin
               w_next = S_LINK;
            end else begin
               w_done = 1'b1;
            end
`else
            w_done = 1'b1;
`endif
         end
`ifdef MC_BL_EN
         S_LINK: begin
            w_resultsrc = 2'b11; w_regw = 1'b1; w_linksel = 1'b1; w_done = 1'b1;
         end
`endif
         S_UNKNOWN: begin w_unknown = 1'b1; w_done = 1'b1; end
         default: w_next = S_FETCH;
      endcase
   end

   // Write enables and pulses are held low while reset is asserted.
   assign bus.IRWrite    = w_irwrite & ~reset;
   assign bus.AdrSrc     = w_adrsrc;
   assign bus.ALUSrcA    = w_alusrca;
   assign bus.ALUSrcB    = w_alusrcb;
   assign bus.ResultSrc  = w_resultsrc;
   assign bus.ALUControl = w_alu_op ? w_cmd_ctrl : 2'b00;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
   assign bus.NextPC     = w_nextpc & ~reset;
   assign bus.RegW       = w_regw & ~reset;
   assign bus.MemW       = w_memw & ~reset;
   assign bus.FlagW      = w_flagw & {2{~reset}};
   assign bus.PCS        = (((bus.Rd == 4'd15) & w_regw) | w_branch) & ~reset;
   assign bus.LinkSel    = w_linksel & ~reset;
   assign bus.InstrDone  = w_done & ~reset;
   assign bus.IllegalOp  = (w_unknown | (w_alu_op & ~w_cmd_ok)) & ~reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a per-instruction reference model
// pushes the expected output vector of every cycle; a negedge monitor compares.
module tb_mc_control_fsm;

   typedef struct packed {
      logic       irw;
      logic       adr;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] res;
      logic [1:0] aluc;
      logic [1:0] imm;
      logic [1:0] regsrc;
      logic       npc;
      logic       regw;
      logic       memw;
      logic [1:0] flagw;
      logic       pcs;
      logic       link;
      logic       done;
      logic       ill;
   } out_t;

`ifdef MC_BL_EN
   localparam bit BL_EN = 1'b1;
`else
   localparam bit BL_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   instr_no = 0;
   out_t exp_q[$];
   int   tag_q[$];
   out_t seq_q[$];

   mc_control_fsm_if bus_if ();

   mc_control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   function automatic out_t actual();
      out_t a;
      a.irw = bus_if.IRWrite;     a.adr = bus_if.AdrSrc;    a.srca = bus_if.ALUSrcA;
      a.srcb = bus_if.ALUSrcB;    a.res = bus_if.ResultSrc; a.aluc = bus_if.ALUControl;
      a.imm = bus_if.ImmSrc;      a.regsrc = bus_if.RegSrc; a.npc = bus_if.NextPC;
      a.regw = bus_if.RegW;       a.memw = bus_if.MemW;     a.flagw = bus_if.FlagW;
      a.pcs = bus_if.PCS;         a.link = bus_if.LinkSel;  a.done = bus_if.InstrDone;
      a.ill = bus_if.IllegalOp;
      return a;
   endfunction

   function automatic out_t base(input logic [1:0] op);
      out_t o = '0;
      o.imm    = op;
      o.regsrc = {op == 2'b01, op == 2'b10};
      return o;
   endfunction

   function automatic out_t fetch_vec(input logic [1:0] op, input bit in_reset);
      out_t o = base(op);
      o.srca = 1'b1; o.srcb = 2'b10; o.res = 2'b10;
      o.irw  = !in_reset; o.npc = !in_reset;
      return o;
   endfunction

   // Reference: builds the whole cycle-by-cycle output trace of one instruction.
   task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
      out_t o;
      logic [3:0] cmd;
      seq_q.delete();
      seq_q.push_back(fetch_vec(op, 1'b0));
      o = base(op); o.srca = 1'b1; o.srcb = 2'b10; o.res = 2'b10;
      seq_q.push_back(o);
      if (op == 2'b01) begin
         o = base(op); o.srcb = 2'b01;
         seq_q.push_back(o);
         o = base(op); o.adr = 1'b1;
         if (f[0]) begin
            seq_q.push_back(o);
            o = base(op); o.res = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'd15); o.done = 1'b1;
         end else begin
            o.memw = 1'b1; o.done = 1'b1;
         end
         seq_q.push_back(o);
      end else if (op == 2'b00) begin
         bit legal, cmp, arith, wr;
         cmd = f[4:1];
         o = base(op);
         o.srcb = f[5] ? 2'b01 : 2'b00;
         legal = 1'b1; cmp = 1'b0; arith = 1'b0;
         if (cmd == 4'b0100) begin o.aluc = 2'b00; arith = 1'b1; end
         else if (cmd == 4'b0010) begin o.aluc = 2'b01; arith = 1'b1; end
         else if (cmd == 4'b0000) o.aluc = 2'b10;
         else if (cmd == 4'b1100) o.aluc = 2'b11;
         else if (cmd == 4'b1010) begin o.aluc = 2'b01; cmp = 1'b1; end
         else legal = 1'b0;
         if (cmp) o.flagw = 2'b11;
         else if (legal) o.flagw = {f[0], f[0] & arith};
         o.ill = !legal;
         seq_q.push_back(o);
         wr = legal && !cmp;
         o = base(op); o.regw = wr; o.pcs = wr && (rd == 4'd15); o.done = 1'b1;
         seq_q.push_back(o);
      end else if (op == 2'b10) begin
         o = base(op); o.srcb = 2'b01; o.res = 2'b10; o.pcs = 1'b1;
         o.done = !(BL_EN && f[4]);
         seq_q.push_back(o);
         if (BL_EN && f[4]) begin
            o = base(op); o.res = 2'b11; o.regw = 1'b1; o.link = 1'b1; o.done = 1'b1;
            o.pcs = (rd == 4'd15);
            seq_q.push_back(o);
         end
      end else begin
         o = base(op); o.ill = 1'b1; o.done = 1'b1;
         seq_q.push_back(o);
      end
   endtask

   // Issue one instruction; keep>0 truncates the trace (used before a reset abort).
   task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                            input logic [3:0] rd, input int keep);
      int n;
      bus_if.Op = op; bus_if.Funct = f; bus_if.Rd = rd;
      model(op, f, rd);
      n = (keep > 0) ? keep : seq_q.size();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(seq_q[i]);
         tag_q.push_back(instr_no * 16 + i);
      end
      instr_no++;
      repeat ((keep > 0) ? n - 1 : n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input int step);
      out_t e, a;
      e = fetch_vec(bus_if.Op, 1'b1);
      a = actual();
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL reset_outputs step %0d: got %h expected %h", step, a, e);
      end
   endtask

   // Monitor: every non-reset cycle with a pending expectation is compared.
   always @(negedge clk) begin
      out_t e, a;
      int t;
      if (!reset && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = actual();
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_outputs instr %0d step %0d: got %h expected %h",
                     t / 16, t % 16, a, e);
         end
      end
   end

   initial begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      logic [3:0] cmds [6];
      cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
      cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b0111;
      bus_if.Op = 2'b00; bus_if.Funct = 6'b000000; bus_if.Rd = 4'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset(0);
      @(posedge clk); #1;
      reset = 1'b0;

      // LDR aborted by reset while in MEMRD
      run_instr(2'b01, 6'b011001, 4'd3, 4);
      @(negedge clk); #1;
      reset = 1'b1;
      #1 check_reset(1);
      repeat (2) @(posedge clk);
      #1 check_reset(2);
      reset = 1'b0;

      run_instr(2'b01, 6'b011001, 4'd3, 0);   // LDR
      run_instr(2'b01, 6'b011000, 4'd4, 0);   // STR
      run_instr(2'b01, 6'b011001, 4'd15, 0);  // LDR to PC
      run_instr(2'b00, 6'b001001, 4'd2, 0);   // ADDS
      run_instr(2'b00, 6'b010101, 4'd0, 0);   // CMP
      run_instr(2'b00, 6'b111000, 4'd15, 0);  // ORR imm to PC
      run_instr(2'b00, 6'b000101, 4'd1, 0);   // SUBS
      run_instr(2'b00, 6'b001110, 4'd5, 0);   // unsupported cmd
      run_instr(2'b10, 6'b100000, 4'd0, 0);   // B
      run_instr(2'b10, 6'b010000, 4'd14, 0);  // BL (plain B when link disabled)
      run_instr(2'b11, 6'b000000, 4'd0, 0);   // undefined opcode
      run_instr(2'b11, 6'b111111, 4'd15, 0);

      for (int k = 0; k < 300; k++) begin
         op = 2'($urandom_range(0, 3));
         f  = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
         rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         run_instr(op, f, rd, 0);
      end

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multicycle ARM-subset processor.
- Decodes the latched instruction fields (Op, Funct, Rd) and sequences the shared datapath (single memory, single ALU) through fetch, decode, execute, memory and writeback states.
- Outputs are the unconditional write requests (RegW, MemW, FlagW, PCS, NextPC). The existing condition-logic block ANDs them with the condition result, so this block never evaluates Cond.

Parameters:
- (none). All field widths are fixed by the ISA subset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Op  in  2  instruction [27:26]
- Funct  in  6  instruction [25:20]
- Rd  in  4  instruction [15:12]
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  out  1  ALU A select: 0 = reg A, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = PC
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- NextPC  out  1  unconditional PC write
- RegW  out  1  register write request
- MemW  out  1  memory write request
- FlagW  out  2  flag write request, [1] = NZ, [0] = CV
- PCS  out  1  PC-source request, equals ((Rd==15) & RegW) | Branch
- LinkSel  out  1  force write address to R14 (optional feature only, else 0)
- InstrDone  out  1  one-cycle pulse in the last state of each instruction
- IllegalOp  out  1  one-cycle pulse in the UNKNOWN state

Behaviour:
- Moore FSM, 4-bit state register, asynchronous reset to FETCH.
- While reset is high, IRWrite, NextPC, RegW, MemW, FlagW, PCS, LinkSel, InstrDone and IllegalOp are forced to 0. All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it; the first edge after release runs FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH.
  - Unused encodings -> FETCH.
- State outputs (unlisted outputs are 0 / don't-care):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=~NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, ALUOp=0.
  - UNKNOWN: no enables asserted, IllegalOp=1.
- InstrDone=1 in MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN.
- ALU decode (combinational, internal ALUOp):
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, cmd = Funct[4:1]: 0100 -> ADD; 0010 -> SUB; 0000 -> AND; 1100 -> ORR; 1010 (CMP) -> SUB with NoWrite=1.
  - ALUOp=1, any other cmd: ALUControl=00, FlagW=00, NoWrite=1, IllegalOp pulses in the execute state.
  - FlagW[1] = Funct[0]; FlagW[0] = Funct[0] & (ADD | SUB); CMP forces FlagW=11.
- FlagW is asserted during EXECUTER/EXECUTEI only. Flags latch at the end of the execute cycle.
- PCS follows RegW within the same state, so Rd=15 writeback redirects the PC in ALUWB/MEMWB.

Optional Feature:
- Macro: MC_BL_EN.
- Defined: in BRANCH, Funct[4]=1 selects next state LINK instead of FETCH. LINK drives ResultSrc=11, RegW=1, LinkSel=1, InstrDone=1 (BRANCH's InstrDone is then 0), then -> FETCH. BL therefore takes 4 cycles.
- Undefined: Funct[4] is ignored, the LINK state does not exist, LinkSel is tied 0, and every branch takes 3 cycles.

Test Plan:
- Reset high for 2 cycles mid-MEMRD, then release -> IRWrite=0 and NextPC=0 while reset is high; the first post-release cycle is FETCH with IRWrite=1, NextPC=1.
- LDR (Op=01, Funct=011001, Rd=3) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegW=1 only in MEMWB, PCS=0, InstrDone pulses cycle 5.
- STR (Op=01, Funct=011000) -> 4 cycles, MemW=1 only in MEMWR, AdrSrc=1 in MEMWR.
- ADDS R-type (Op=00, Funct=001001, Rd=2) -> EXECUTER with ALUControl=00 and FlagW=11, then ALUWB with RegW=1. CMP (Funct=010101) -> FlagW=11, ALUWB with RegW=0.
- MOV-like ORR to PC (Op=00, Funct=111000, Rd=15) -> EXECUTEI, then ALUWB with RegW=1 and PCS=1. B (Op=10, Funct=100000) -> BRANCH with PCS=1, 3 cycles total.
- Op=11 -> UNKNOWN with IllegalOp=1 for exactly one cycle, then FETCH. With MC_BL_EN, Funct=010000 on Op=10 -> LINK with LinkSel=1, ResultSrc=11, RegW=1.
